// File: rtl/fsk_demodulator.sv
// rtl/fsk_demodulator.sv - square-wave FSK demodulator: half-period measurement, IDLE/ACQ/TRACK lock FSM
// Optional macro FSK_DEMOD_FILTER_EN: a classification must repeat before it is accepted.
module fsk_demodulator #(
   parameter int HALF_PERIOD_0 = 100,
   parameter int HALF_PERIOD_1 = 50,
   parameter int TOLERANCE     = 10,
   parameter int TIMEOUT       = 400,
   parameter int CNT_W         = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic fsk_in,
   output logic data_out,
   output logic data_valid,
   output logic data_chg,
   output logic sym_err,
   output logic carrier_lost
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACQ   = 2'd1;
   localparam logic [1:0] S_TRACK = 2'd2;

   localparam logic [CNT_W-1:0]        TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic signed [CNT_W:0]   HP0_C     = (CNT_W+1)'(HALF_PERIOD_0);
   localparam logic signed [CNT_W:0]   HP1_C     = (CNT_W+1)'(HALF_PERIOD_1);
   localparam logic signed [CNT_W:0]   TOL_C     = (CNT_W+1)'(TOLERANCE);
   localparam logic signed [CNT_W:0]   ONE_C     = (CNT_W+1)'(1);

   logic             sync1, fsk_s, fsk_d;
   logic             edge_det;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       state, state_nxt;
   logic             timeout;

   logic signed [CNT_W:0] meas, diff0, diff1, mag0, mag1;
   logic             is0, is1, cls_valid, cls_bit, qualified;
   logic             load_data, chg_pulse, err_pulse;

   assign edge_det = fsk_s ^ fsk_d;
   assign timeout  = (cnt == TIMEOUT_C) && !edge_det;

   // Measured half-period is cnt+1, evaluated one bit wider and signed so nothing wraps
   always_comb begin
      meas      = $signed({1'b0, cnt}) + ONE_C;
      diff0     = meas - HP0_C;
      diff1     = meas - HP1_C;
      mag0      = (diff0 < 0) ? -diff0 : diff0;
      mag1      = (diff1 < 0) ? -diff1 : diff1;
      is0       = (mag0 <= TOL_C);
      is1       = (mag1 <= TOL_C);
      cls_valid = is0 | is1;
      cls_bit   = !is0;
   end

`ifdef FSK_DEMOD_FILTER_EN
   logic hist_valid, hist_bit;
   assign qualified = cls_valid && hist_valid && (hist_bit == cls_bit);
`else
   assign qualified = cls_valid;
`endif

   always_comb begin
      state_nxt = state;
      load_data = 1'b0;
      chg_pulse = 1'b0;
      err_pulse = 1'b0;
      case (state)
         S_IDLE: begin
            if (edge_det) state_nxt = S_ACQ;
         end
         S_ACQ: begin
            if (edge_det) begin
               if (qualified) begin
                  load_data = 1'b1;
                  state_nxt = S_TRACK;
               end
            end else if (timeout) begin
               state_nxt = S_IDLE;
            end
         end
         S_TRACK: begin
            if (edge_det) begin
               if (qualified && (cls_bit != data_out)) begin
                  load_data = 1'b1;
                  chg_pulse = 1'b1;
               end else if (!cls_valid) begin
                  err_pulse = 1'b1;
               end
            end else if (timeout) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1        <= 1'b0;
         fsk_s        <= 1'b0;
         fsk_d        <= 1'b0;
         cnt          <= '0;
         state        <= S_IDLE;
         data_out     <= 1'b0;
         data_valid   <= 1'b0;
         data_chg     <= 1'b0;
         sym_err      <= 1'b0;
         carrier_lost <= 1'b1;
      end else begin
         sync1        <= fsk_in;
         fsk_s        <= sync1;
         fsk_d        <= fsk_s;
         if (edge_det)
            cnt <= '0;
         else if (cnt != TIMEOUT_C)
            cnt <= cnt + 1'b1;
         state        <= state_nxt;
         if (load_data)
            data_out <= cls_bit;
         data_chg     <= chg_pulse;
         sym_err      <= err_pulse;
         data_valid   <= (state_nxt == S_TRACK);
         carrier_lost <= (state_nxt == S_IDLE);
      end
   end

`ifdef FSK_DEMOD_FILTER_EN
   // History only lives while locked or acquiring; IDLE edges never classify
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_valid <= 1'b0;
         hist_bit   <= 1'b0;
      end else if ((state == S_IDLE) || (state_nxt == S_IDLE)) begin
         hist_valid <= 1'b0;
         hist_bit   <= 1'b0;
      end else if (edge_det) begin
         hist_valid <= cls_valid;
         hist_bit   <= cls_bit;
      end
   end
`endif

endmodule

// File: tb/tb_fsk_demodulator.sv
// tb/tb_fsk_demodulator.sv - table-driven scoreboard bench for fsk_demodulator
module tb_fsk_demodulator;

`ifdef FSK_DEMOD_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic fsk_in = 1'b0;
   logic data_out, data_valid, data_chg, sym_err, carrier_lost;

   fsk_demodulator dut (
      .clk(clk), .rst(rst), .fsk_in(fsk_in),
      .data_out(data_out), .data_valid(data_valid), .data_chg(data_chg),
      .sym_err(sym_err), .carrier_lost(carrier_lost)
   );

   always #5 clk = ~clk;

   typedef struct {
      int w;
      bit out, val, chg, err, lost;
   } vec_t;

   typedef struct {
      int due;
      bit out, val, chg, err, lost;
   } exp_t;

   vec_t tbl [0:63];
   int   n_tbl = 0;
   exp_t sb [$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   chg_cnt = 0;
   int   err_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (data_chg) chg_cnt++;
         if (sym_err)  err_cnt++;
      end
      if (sb.size() > 0 && sb[0].due < cyc) begin
         chk("sb_missed_slot", cyc, sb[0].due);
         void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
         chk("data_out",     data_out,     sb[0].out);
         chk("data_valid",   data_valid,   sb[0].val);
         chk("data_chg",     data_chg,     sb[0].chg);
         chk("sym_err",      sym_err,      sb[0].err);
         chk("carrier_lost", carrier_lost, sb[0].lost);
         void'(sb.pop_front());
      end
   end

   task automatic add(input int w, input bit o, input bit v, input bit c, input bit e, input bit l);
      tbl[n_tbl] = '{w: w, out: o, val: v, chg: c, err: e, lost: l};
      n_tbl++;
   endtask

   // Output effects of an fsk_in transition appear three clocks later
   task automatic apply(input vec_t v);
      exp_t e;
      repeat (v.w) @(negedge clk);
      fsk_in = ~fsk_in;
      e = '{due: cyc + 3, out: v.out, val: v.val, chg: v.chg, err: v.err, lost: v.lost};
      sb.push_back(e);
   endtask

   task automatic run_range(input int lo, input int hi);
      for (int i = lo; i < hi; i++) apply(tbl[i]);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_data_out"},     data_out,     0);
      chk({tag, "_data_valid"},   data_valid,   0);
      chk({tag, "_data_chg"},     data_chg,     0);
      chk({tag, "_sym_err"},      sym_err,      0);
      chk({tag, "_carrier_lost"}, carrier_lost, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a_end, b_end, c_end;
      // Phase A: acquire on '0' tone, glitches, then switch to '1' tone
      add(20, 0, 0, 0, 0, 0);
      add(100, 0, !FILT, 0, 0, 0);
      for (int i = 0; i < 12; i++) add(100, 0, 1, 0, 0, 0);
      add(75, 0, 1, 0, 1, 0);
      add(100, 0, 1, 0, 0, 0);
      add(100, 0, 1, 0, 0, 0);
      add(50, !FILT, 1, !FILT, 0, 0);
      add(100, 0, 1, !FILT, 0, 0);
      add(100, 0, 1, 0, 0, 0);
      add(50, !FILT, 1, !FILT, 0, 0);
      add(50, 1, 1, FILT, 0, 0);
      for (int i = 0; i < 3; i++) add(50, 1, 1, 0, 0, 0);
      add(59, 1, 1, 0, 0, 0);
      add(41, 1, 1, 0, 0, 0);
      a_end = n_tbl;
      // Phase B: reacquire after carrier loss; data_out still holds 1 in ACQ
      add(20, 1, 0, 0, 0, 0);
      add(100, FILT, !FILT, 0, 0, 0);
      add(110, 0, 1, 0, 0, 0);
      add(90, 0, 1, 0, 0, 0);
      b_end = n_tbl;
      // Phase C: recovery after mid-TRACK reset
      add(20, 0, 0, 0, 0, 0);
      add(100, 0, !FILT, 0, 0, 0);
      add(100, 0, 1, 0, 0, 0);
      c_end = n_tbl;

      repeat (3) @(negedge clk);
      chk_reset_vals("por");
      rst = 1'b0;

      run_range(0, a_end);

      // Carrier loss exactly 401 cycles after the last edge cycle
      repeat (403) @(negedge clk);
      chk("pre_timeout_lost",  carrier_lost, 0);
      chk("pre_timeout_valid", data_valid,   1);
      @(negedge clk);
      chk("timeout_lost",  carrier_lost, 1);
      chk("timeout_valid", data_valid,   0);
      chk("timeout_hold",  data_out,     1);

      run_range(a_end, b_end);

      repeat (30) @(negedge clk);
      rst = 1'b1;
      fsk_in = 1'b0;
      #1;
      chk_reset_vals("mid_rst");
      repeat (2) @(negedge clk);
      chk_reset_vals("rst_hold");
      rst = 1'b0;

      run_range(b_end, c_end);
      repeat (10) @(negedge clk);
      chk("relock_valid", data_valid,   1);
      chk("relock_out",   data_out,     0);
      chk("relock_lost",  carrier_lost, 0);

      repeat (5) @(negedge clk);
      chk("sb_drained",   sb.size(), 0);
      chk("total_chg",    chg_cnt,   FILT ? 1 : 3);
      chk("total_symerr", err_cnt,   1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fsk_demodulator.md
FSK_DEMODULATOR -- requirements
Module: fsk_demodulator

Interface
REQ-001 SHALL have parameter HALF_PERIOD_0, default 100, nominal half-period in clk cycles of a '0' tone.
REQ-002 SHALL have parameter HALF_PERIOD_1, default 50, nominal half-period in clk cycles of a '1' tone.
REQ-003 SHALL have parameter TOLERANCE, default 10, maximum accepted |measured - nominal| in cycles, inclusive.
REQ-004 SHALL have parameter TIMEOUT, default 400, number of edge-free cycles that declares carrier loss.
REQ-005 SHALL have parameter CNT_W, default 10, counter width; must satisfy 2^CNT_W > TIMEOUT.
REQ-006 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port fsk_in  input  1  asynchronous square-wave FSK signal.
REQ-009 SHALL have port data_out  output  1  recovered data bit.
REQ-010 SHALL have port data_valid  output  1  high while the state is TRACK.
REQ-011 SHALL have port data_chg  output  1  one-cycle pulse when data_out changes value.
REQ-012 SHALL have port sym_err  output  1  one-cycle pulse on an out-of-tolerance half-period while in TRACK.
REQ-013 SHALL have port carrier_lost  output  1  high while the state is IDLE.

Function
REQ-014 SHALL pass fsk_in through a 2-flop synchronizer (fsk_s) and SHALL detect any edge as fsk_s differing from its 1-cycle delayed copy.
REQ-015 SHALL keep a cycle counter cnt that clears to 0 on an edge cycle, otherwise increments, saturating at TIMEOUT.
REQ-016 SHALL take the measured half-period L = cnt+1 on each edge cycle.
REQ-017 SHALL classify L as '0' if |L-HALF_PERIOD_0| <= TOLERANCE, as '1' if |L-HALF_PERIOD_1| <= TOLERANCE, else as invalid; '0' wins if both match.
REQ-018 SHALL compute the differences at CNT_W+1 bits signed, with no wrap.
REQ-019 SHALL implement states IDLE, ACQ, TRACK.
REQ-020 IDLE: on the first edge SHALL go to ACQ, with no classification made.
REQ-021 ACQ: on an edge with a qualified classification (REQ-030) SHALL load data_out, go to TRACK, and SHALL NOT pulse data_chg; invalid L SHALL keep ACQ with no sym_err.
REQ-022 TRACK: a qualified classification differing from data_out SHALL update data_out and pulse data_chg in the same cycle.
REQ-023 TRACK: invalid L SHALL pulse sym_err, hold data_out, and remain in TRACK.
REQ-024 ACQ or TRACK: when cnt equals TIMEOUT with no edge in that cycle, SHALL go to IDLE next cycle, holding data_out.
REQ-025 SHALL give an edge precedence over timeout when both occur in the same cycle.
REQ-026 SHALL register all outputs, so data_out/data_chg/sym_err change one clk after the edge cycle (three clk after the fsk_in transition).

Reset
REQ-027 rst SHALL asynchronously force: state IDLE, synchronizer flops 0, cnt 0, filter register cleared.
REQ-028 rst SHALL asynchronously force outputs data_out=0, data_valid=0, data_chg=0, sym_err=0, carrier_lost=1.
REQ-029 reset asserted mid-TRACK SHALL discard the in-progress measurement; the first post-reset edge SHALL be treated as in IDLE.

Configuration
REQ-030 With FSK_DEMOD_FILTER_EN defined, a classification SHALL qualify only when it equals the previous valid classification; an invalid L or leaving TRACK/ACQ clears the history. Without the macro, every valid classification SHALL qualify immediately.

Verification
REQ-031 fsk_in toggling every 100 cycles for 2000 cycles -> data_valid=1, data_out=0, carrier_lost=0 within 210 cycles (310 with filter); no sym_err.
REQ-032 Toggling every 50 cycles after a 0 lock -> data_out=1 with exactly one data_chg pulse; no sym_err.
REQ-033 In TRACK on 100-cycle tone, insert one 75-cycle half-period -> one sym_err pulse; data_out stays 0; data_valid stays 1.
REQ-034 In TRACK on 100-cycle tone, insert one 50-cycle half-period -> with FSK_DEMOD_FILTER_EN data_out stays 0, no data_chg; without it data_out goes 1 then back to 0 with two data_chg pulses.
REQ-035 Hold fsk_in constant after lock -> carrier_lost=1, data_valid=0 exactly 401 cycles after the last edge cycle; data_out held.
REQ-036 Assert rst for 2 cycles mid-TRACK -> all outputs at reset values immediately; lock recovers per REQ-031 timing.
